bram_port_arbiter: RTL

- Shares the single BRAM port (addr/wrdata/we/rddata) between two requesters:
  - port 0: host-side loader, which fills operands and the mask.
  - port 1: the PE-array controller, which does the LOAD/HARV traffic.
- Sits between the requesters and the BRAM.
- Burst-oriented ownership with a round-robin tie-break, so the loader and the compute pass cannot corrupt each other's BRAM accesses.

---
 rtl/bram_port_arbiter_if.sv | 17 +
 rtl/bram_port_arbiter.sv | 130 +++++++++++++
 2 files changed

// File: rtl/bram_port_arbiter_if.sv
// Requester-side view of the shared BRAM port: burst request, address/data/byte enables,
// plus the grant and read-valid returned by the arbiter.
interface bram_port_arbiter_if #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 32,
  parameter int WE_WIDTH   = 4
);
  logic                  req;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wrdata;
  logic [WE_WIDTH-1:0]   we;
  logic                  gnt;
  logic                  rvalid;

  modport master (output req, addr, wrdata, we, input gnt, rvalid);
  modport slave  (input req, addr, wrdata, we, output gnt, rvalid);
endinterface

// File: rtl/bram_port_arbiter.sv
// Burst-owned, round-robin share of one BRAM port; gnt 1 cycle after req, rvalid 1 cycle after a read.
// Waiting requesters hold req until granted; ARB_TIMEOUT_EN adds MAX_HOLD-cycle preemption.
module bram_port_arbiter #(
  parameter int BRAM_ADDR_WIDTH = 15,
  parameter int BRAM_DATA_WIDTH = 32,
  parameter int BRAM_WE_WIDTH   = 4,
  parameter int MAX_HOLD        = 64
) (
  input  logic                       clk,
  input  logic                       resetn,
  bram_port_arbiter_if.slave         p0,
  bram_port_arbiter_if.slave         p1,
  output logic [BRAM_DATA_WIDTH-1:0] rddata,
  output logic [BRAM_ADDR_WIDTH-1:0] bram_addr,
  output logic [BRAM_DATA_WIDTH-1:0] bram_wrdata,
  output logic [BRAM_WE_WIDTH-1:0]   bram_we,
  input  logic [BRAM_DATA_WIDTH-1:0] bram_rddata,
  output logic                       busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;

  state_t state, state_nxt;
  logic   last, last_nxt;
  logic   acc0, acc1;
  logic   preempt0, preempt1;
  logic   rvalid0_q, rvalid1_q;

  if (MAX_HOLD < 1) begin : g_bad_max_hold
    $error("MAX_HOLD must be at least 1");
  end

  assign acc0 = p0.req & (state == OWN0);
  assign acc1 = p1.req & (state == OWN1);

`ifdef ARB_TIMEOUT_EN
  localparam int                HOLD_W    = $clog2(MAX_HOLD) + 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  logic [HOLD_W-1:0] hold_cnt;

  assign preempt0 = acc0 & p1.req & (hold_cnt == HOLD_LAST);
  assign preempt1 = acc1 & p0.req & (hold_cnt == HOLD_LAST);

  // Saturates at the limit so an uncontested owner never wraps back below it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      hold_cnt <= '0;
    else if (state_nxt != state)
      hold_cnt <= '0;
    else if ((acc0 | acc1) && (hold_cnt != HOLD_LAST))
      hold_cnt <= hold_cnt + HOLD_W'(1);
  end
`else
  assign preempt0 = 1'b0;
  assign preempt1 = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    case (state)
      IDLE: begin
        if (p0.req && p1.req)
          state_nxt = last ? OWN0 : OWN1;
        else if (p0.req)
          state_nxt = OWN0;
        else if (p1.req)
          state_nxt = OWN1;
      end
      OWN0: begin
        if (!p0.req || preempt0) begin
          last_nxt  = 1'b0;
          state_nxt = p1.req ? OWN1 : IDLE;
        end
      end
      OWN1: begin
        if (!p1.req || preempt1) begin
          last_nxt  = 1'b1;
          state_nxt = p0.req ? OWN0 : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Only a live access reaches the BRAM; the handoff cycle (gnt high, req low) is idle.
  always_comb begin
    bram_addr   = '0;
    bram_wrdata = '0;
    bram_we     = '0;
    if (acc0) begin
      bram_addr   = p0.addr;
      bram_wrdata = p0.wrdata;
      bram_we     = p0.we;
    end else if (acc1) begin
      bram_addr   = p1.addr;
      bram_wrdata = p1.wrdata;
      bram_we     = p1.we;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      rvalid0_q <= acc0 & (p0.we == '0);
      rvalid1_q <= acc1 & (p1.we == '0);
    end
  end

  assign p0.gnt    = (state == OWN0);
  assign p1.gnt    = (state == OWN1);
  assign p0.rvalid = rvalid0_q;
  assign p1.rvalid = rvalid1_q;
  assign rddata    = bram_rddata;
  assign busy      = (state != IDLE);

endmodule
